// File: rtl/izh_pkg.sv
// Shared constants and state encoding for the synapse accumulator.
// Values are two's complement with 8 fractional bits.
package izh_pkg;

    localparam int W    = 17;
    localparam int FRAC = 8;

    localparam logic [W-1:0] SAT_MAX = 17'h0FFFF;
    localparam logic [W-1:0] SAT_MIN = 17'h10000;
    localparam logic [W-1:0] ONE     = 17'h00100;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder: clamps to SAT_MAX/SAT_MIN instead of wrapping.
module sat_add
    import izh_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] raw;

    assign raw = a + b;

    // Overflow only when both operands share a sign that the raw result lost.
    always_comb begin
        sum = raw;
        if ((a[W-1] == b[W-1]) && (raw[W-1] != a[W-1])) begin
            sum = a[W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/synapse_accumulator.sv
// Turns one timestep's spike vector into per-target input currents by summing
// weight rows of firing sources, then streams the currents out one target at a time.
module synapse_accumulator #(
    parameter int N     = 16,
    parameter int IDX_W = 4,
    parameter int W     = izh_pkg::W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spk_valid,
    output logic             spk_ready,
    input  logic [N-1:0]     spk_fired,
    input  logic [W-1:0]     bias,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_src,
    input  logic [IDX_W-1:0] wr_dst,
    input  logic [W-1:0]     wr_data,
    output logic             cur_valid,
    input  logic             cur_ready,
    output logic [IDX_W-1:0] cur_idx,
    output logic [W-1:0]     cur_i,
    output logic             cur_last,
    output logic             busy
);

    import izh_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   src_reg, src_next;
    logic [IDX_W-1:0]   dst_reg, dst_next;
    logic [N-1:0]       fired_reg;
    logic [W-1:0]       bias_reg;
    logic [W-1:0]       acc_reg [N];
    logic [W-1:0]       w_reg [N*N];

    logic               accept;
    logic               wr_ok;
    logic               acc_we;
    logic               acc_clr;
    logic [W-1:0]       acc_cur;
    logic [W-1:0]       w_cur;
    logic [W-1:0]       acc_sum;
    logic [W-1:0]       out_sum;

    assign accept  = (state_reg == IDLE) && spk_valid;
    assign wr_ok   = (state_reg == IDLE) && wr_en;
    assign acc_cur = acc_reg[dst_reg];
    assign w_cur   = w_reg[{src_reg, dst_reg}];

    sat_add u_acc_add (
        .a   (acc_cur),
        .b   (w_cur),
        .sum (acc_sum)
    );

    sat_add u_out_add (
        .a   (acc_cur),
        .b   (bias_reg),
        .sum (out_sum)
    );

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        acc_we     = 1'b0;
        acc_clr    = 1'b0;
        spk_ready  = 1'b0;
        cur_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                spk_ready = 1'b1;
                if (spk_valid) begin
                    src_next   = '0;
                    dst_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                // A silent source costs one cycle; a firing one sweeps every target.
                if (!fired_reg[src_reg]) begin
                    src_next = src_reg + 1'b1;
                    if (src_reg == LAST_IDX) begin
                        dst_next   = '0;
                        state_next = EMIT;
                    end
                end else begin
                    acc_we = 1'b1;
                    if (dst_reg == LAST_IDX) begin
                        dst_next = '0;
                        src_next = src_reg + 1'b1;
                        if (src_reg == LAST_IDX) begin
                            state_next = EMIT;
                        end
                    end else begin
                        dst_next = dst_reg + 1'b1;
                    end
                end
            end
            EMIT: begin
                cur_valid = 1'b1;
                if (cur_ready) begin
                    acc_clr  = 1'b1;
                    dst_next = dst_reg + 1'b1;
                    if (dst_reg == LAST_IDX) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            fired_reg <= '0;
            bias_reg  <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            if (accept) begin
                fired_reg <= spk_fired;
                bias_reg  <= bias;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N * N; gi++) begin : g_weight
            always_ff @(posedge clk) begin
                if (rst) begin
                    w_reg[gi] <= '0;
                end else if (wr_ok && ({wr_src, wr_dst} == (2 * IDX_W)'(gi))) begin
                    w_reg[gi] <= wr_data;
                end
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_acc
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg[gi] <= '0;
                end else if (dst_reg == IDX_W'(gi)) begin
                    if (acc_we) begin
                        acc_reg[gi] <= acc_sum;
                    end else if (acc_clr) begin
                        acc_reg[gi] <= '0;
                    end
                end
            end
        end
    endgenerate

    // Outputs are forced to zero outside EMIT so idle values never leak stale data.
    assign cur_idx  = cur_valid ? dst_reg : '0;
    assign cur_i    = cur_valid ? out_sum : '0;
    assign cur_last = cur_valid && (dst_reg == LAST_IDX);
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator: an arithmetic model of the currents plus
// a per-cycle compare process on the output stream.
module tb_synapse_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spk_valid = 1'b0;
    logic        spk_ready;
    logic [15:0] spk_fired = '0;
    logic [16:0] bias = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_src = '0;
    logic [3:0]  wr_dst = '0;
    logic [16:0] wr_data = '0;
    logic        cur_valid;
    logic        cur_ready = 1'b1;
    logic [3:0]  cur_idx;
    logic [16:0] cur_i;
    logic        cur_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [16:0] mw [16][16];
    logic [16:0] exp_cur [16];
    logic [16:0] cap [16];
    int          run_id = 0;
    int          last_lat = 0;

    synapse_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_fired (spk_fired),
        .bias      (bias),
        .wr_en     (wr_en),
        .wr_src    (wr_src),
        .wr_dst    (wr_dst),
        .wr_data   (wr_data),
        .cur_valid (cur_valid),
        .cur_ready (cur_ready),
        .cur_idx   (cur_idx),
        .cur_i     (cur_i),
        .cur_last  (cur_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > 65535) return 65535;
        if (v < -65536) return -65536;
        return v;
    endfunction

    function automatic int sx(input logic [16:0] x);
        return int'($signed(x));
    endfunction

    // Expected currents straight from the arithmetic rules: per-target running sum
    // over firing sources in ascending order, each step clamped, then bias added.
    task automatic model_run(input logic [15:0] f, input logic [16:0] b);
        int a;
        logic [31:0] t;
        for (int d = 0; d < 16; d++) begin
            a = 0;
            for (int s = 0; s < 16; s++) begin
                if (f[s]) a = clampi(a + sx(mw[s][d]));
            end
            t = clampi(a + sx(b));
            exp_cur[d] = t[16:0];
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 16; s++)
            for (int d = 0; d < 16; d++)
                mw[s][d] = '0;
    endtask

    // Per-cycle output checker; the expected index advances on each handshake.
    int          exp_idx = 0;
    int          seen_run = 0;
    bit          prev_stall = 1'b0;
    logic [3:0]  prev_idx;
    logic [16:0] prev_i;

    always @(negedge clk) begin
        if (run_id != seen_run) begin
            seen_run = run_id;
            exp_idx  = 0;
        end
        if (!rst && cur_valid) begin
            if (exp_idx > 15) begin
                chk("extra_valid", 32'(cur_valid), 32'd0);
            end else begin
                chk("cur_idx", 32'(cur_idx), 32'(exp_idx));
                chk("cur_i", 32'(cur_i), 32'(exp_cur[exp_idx]));
                chk("cur_last", 32'(cur_last), 32'(exp_idx == 15));
                cap[exp_idx] = cur_i;
            end
            if (prev_stall) begin
                chk("hold_idx", 32'(cur_idx), 32'(prev_idx));
                chk("hold_i", 32'(cur_i), 32'(prev_i));
            end
            if (cur_ready) exp_idx++;
            prev_stall = !cur_ready;
            prev_idx   = cur_idx;
            prev_i     = cur_i;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_w(input int s, input int d, input logic [16:0] v);
        wr_en   = 1'b1;
        wr_src  = 4'(s);
        wr_dst  = 4'(d);
        wr_data = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mw[s][d] = v;
    endtask

    // One full spike-to-current transaction; optional stall, busy-time write, or reset abort.
    task automatic run(input logic [15:0] f, input logic [16:0] b, input int stall_idx,
                       input int stall_len, input bit busy_wr, input int rst_at);
        int lat;
        int cyc;
        int stall_cnt;
        int pc;
        bit got_last;
        bit hs_last;
        model_run(f, b);
        pc = $countones(f);
        run_id++;
        chk("spk_ready_idle", 32'(spk_ready), 32'd1);
        spk_valid = 1'b1;
        spk_fired = f;
        bias      = b;
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        if (busy_wr) begin
            wr_en   = 1'b1;
            wr_src  = 4'd0;
            wr_dst  = 4'd0;
            wr_data = 17'h00100;
        end
        lat = 1;
        while (!cur_valid && lat < 600) begin
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            lat++;
        end
        wr_en    = 1'b0;
        last_lat = lat;
        chk("first_valid_latency", 32'(lat), 32'((16 - pc) + 16 * pc + 1));
        chk("spk_ready_busy", 32'(spk_ready), 32'd0);
        got_last  = 1'b0;
        cyc       = 0;
        stall_cnt = 0;
        while (!got_last && cyc < 100) begin
            if (rst_at >= 0 && cur_valid && int'(cur_idx) == rst_at) begin
                cur_ready = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_cur_valid", 32'(cur_valid), 32'd0);
                chk("rst_spk_ready", 32'(spk_ready), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                rst = 1'b0;
                cur_ready = 1'b1;
                clear_model();
                $display("run fired=%h bias=%h aborted by reset at idx %0d", f, b, rst_at);
                return;
            end
            cur_ready = 1'b1;
            if (cur_valid && int'(cur_idx) == stall_idx && stall_cnt < stall_len) begin
                cur_ready = 1'b0;
                stall_cnt++;
            end
            hs_last = cur_valid && cur_ready && cur_last;
            @(posedge clk);
            #1;
            cyc++;
            if (hs_last) got_last = 1'b1;
        end
        cur_ready = 1'b1;
        chk("stream_done", 32'(got_last), 32'd1);
        chk("spk_ready_after", 32'(spk_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        $display("run fired=%h bias=%h latency=%0d stream_cycles=%0d", f, b, lat, cyc);
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_spk_ready", 32'(spk_ready), 32'd1);
        chk("reset_cur_valid", 32'(cur_valid), 32'd0);
        chk("reset_cur_idx", 32'(cur_idx), 32'd0);
        chk("reset_cur_i", 32'(cur_i), 32'd0);
        chk("reset_cur_last", 32'(cur_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single synapse.
        write_w(2, 5, 17'h00280);
        run(16'h0004, 17'h00100, -1, 0, 1'b0, -1);
        chk("single_lat", 32'(last_lat), 32'd32);
        chk("single_idx5", 32'(cap[5]), 32'h00380);
        chk("single_idx0", 32'(cap[0]), 32'h00100);
        chk("single_idx15", 32'(cap[15]), 32'h00100);

        // Same vector with backpressure at idx 7; identical results show the clear.
        run(16'h0004, 17'h00100, 7, 5, 1'b0, -1);
        chk("repeat_idx5", 32'(cap[5]), 32'h00380);
        chk("repeat_idx7", 32'(cap[7]), 32'h00100);

        // Positive saturation.
        for (int s = 0; s < 16; s++) write_w(s, 0, 17'h0FF00);
        run(16'hFFFF, 17'h00000, -1, 0, 1'b0, -1);
        chk("possat_lat", 32'(last_lat), 32'd257);
        chk("possat_idx0", 32'(cap[0]), 32'h0FFFF);
        chk("possat_idx5", 32'(cap[5]), 32'h00280);

        // Negative saturation.
        for (int s = 0; s < 16; s++) write_w(s, 3, 17'h1F000);
        run(16'hFFFF, 17'h1FF00, -1, 0, 1'b0, -1);
        chk("negsat_idx3", 32'(cap[3]), 32'h10000);
        chk("negsat_idx0", 32'(cap[0]), 32'h0FEFF);

        // Write during busy is dropped.
        do_reset();
        run(16'h0001, 17'h00000, -1, 0, 1'b1, -1);
        run(16'h0001, 17'h00000, -1, 0, 1'b0, -1);
        chk("busywr_idx0", 32'(cap[0]), 32'h00000);

        // Reset mid-EMIT, then weights must read back as zero.
        write_w(0, 4, 17'h00100);
        run(16'h0001, 17'h00040, -1, 0, 1'b0, 4);
        run(16'h0001, 17'h00040, -1, 0, 1'b0, -1);
        chk("postrst_idx4", 32'(cap[4]), 32'h00040);
        chk("postrst_idx0", 32'(cap[0]), 32'h00040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
